alu_result_queue: RTL
=====================

// Module: alu_result_queue
// PURPOSE
//  Downstream stage of the combinational sign-magnitude mul/div units.
//  Captures each result {R[4:0] sign-magnitude, SF, ZF, DZF}, canonicalises it and
//  buffers it in a small FIFO with valid/ready on both sides.
//  Presents both sign-magnitude and two's-complement forms to the consumer
//  (writeback / file-dump logic).
//  Cross-checks upstream flags and keeps sticky error status.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2.
//  RW     5  result width: 1 sign bit + (RW-1) magnitude bits.
// PORTS
//  clk          in   1      single clock, rising edge.
//  rst_n        in   1      asynchronous, active-low reset.
//  in_valid     in   1      upstream result valid.
//  in_ready     out  1      queue can accept this cycle.
//  in_r         in   RW     sign-magnitude result; in_r[RW-1] is the sign.
//  in_sf        in   1      upstream sign flag.
//  in_zf        in   1      upstream zero flag.
//  in_dzf       in   1      upstream divide-by-zero flag.
//  out_valid    out  1      head entry valid.
//  out_ready    in   1      consumer accepts head.
//  out_r        out  RW     canonical sign-magnitude result.
//  out_tc       out  RW     two's-complement result.
//  out_sf       out  1      canonical sign flag.
//  out_zf       out  1      canonical zero flag.
//  out_dzf      out  1      canonical divide-by-zero flag.
//  count        out  $clog2(DEPTH)+1  occupied entries.
//  clr_sticky   in   1      synchronous clear of sticky bits.
//  sticky_dzf   out  1      a DZF entry has been pushed since the last clear.
//  flag_err     out  1      sticky: upstream SF/ZF disagreed with recomputed flags.
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - count=0, out_valid=0, in_ready=1;
//   - out_r/out_tc/out_* flags = 0;
//   - sticky_dzf=0, flag_err=0; pointers=0.
//  Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//  Latency and ordering:
//   - first-word-fall-through; push into empty queue -> out_valid the next cycle;
//   - strict FIFO order.
//  in_ready = (count<DEPTH) || pop.
//   - Full with simultaneous pop accepts the push; count stays DEPTH.
//  Simultaneous push and pop at any occupancy: count unchanged, both pointers advance.
//  Pointers are mod DEPTH; wrap-around is silent.
//  Pop when empty, or push when full without a pop: impossible by the handshake.
//   - Never corrupts state.
//  Canonicalisation at push (combinational on input; stored entry is canonical):
//   - in_dzf=1: r=0, sf=0, zf=0, dzf=1.
//   - mag==0 (incl. negative zero 10000): r=00000, sf=0, zf=1, dzf=0.
//   - else: r=in_r, sf=in_r[RW-1], zf=0, dzf=0.
//  out_tc = sign ? -{1'b0,mag} : {1'b0,mag}, computed RW-bit.
//   - Magnitude range 0..2^(RW-1)-1 always fits (e.g. 10011 -> 11101).
//  flag_err:
//   - set on a push with in_dzf=0 where in_sf!=canonical sf or in_zf!=canonical zf;
//   - exception: negative zero with in_sf=1 does not set it.
//  sticky_dzf is set on a push with in_dzf=1.
//  clr_sticky:
//   - clears both sticky bits;
//   - a same-cycle set event wins (bit stays 1).
//  Outputs are driven from the head entry.
//   - The data outputs are don't-care when out_valid=0; the bench checks them only while valid.
//  Reset mid-operation: all entries discarded, state as at reset.
// STRUCTURE
//  Shared include alu_defs.vh:
//   - localparams RW=5 and flag bit positions;
//   - packed entry layout {dzf,zf,sf,r[RW-1:0]} (ENTRY_W=RW+3).
//  Sub-module sm_canon (combinational):
//   - in: in_r, in_sf, in_zf, in_dzf;
//   - out: canonical entry and mismatch bit.
//  Top holds the register-array FIFO, pointers, count, stickies and the two's-complement output conversion.
// TESTING
//  T1 reset: rst_n low mid-traffic -> count=0, out_valid=0, in_ready=1, stickies=0, immediately (async).
//  T2 push in_r=10110 (-6), sf=1, zf=0:
//   - next cycle out_valid=1, out_r=10110, out_tc=11010, out_sf=1;
//   - flag_err stays 0.
//  T3 negative zero: push in_r=10000, sf=1, zf=1 -> out_r=00000, out_sf=0, out_zf=1, out_tc=0, flag_err=0.
//  T4 DZF: push in_r=00011 with in_dzf=1 -> out_r=0, out_dzf=1, out_zf=0, sticky_dzf=1.
//   - Then clr_sticky -> 0.
//  T5 fill and drain:
//   - out_ready=0, 4 pushes of +1..+4 -> count=4, in_ready=0;
//   - then push +5 with out_ready=1 -> accepted, count stays 4;
//   - drain order is 1,2,3,4,5.
//  T6 flag cross-check: push in_r=01001 (+9) with in_sf=1 -> flag_err=1, out_sf=0.
//   - Sweep all 7x7 products of -3..3 from the mul unit; every out_tc equals A*B.

Source files
------------

// File: rtl/alu_result_queue_pkg.sv
// Shared definitions for the ALU result queue: default result width and the
// packed entry layout {dzf, zf, sf, r[RW-1:0]}.
package alu_result_queue_pkg;

  localparam int RW_DEF = 5;

  // Flag bit offsets above the result field within a packed entry.
  localparam int SF_OFS  = 0;
  localparam int ZF_OFS  = 1;
  localparam int DZF_OFS = 2;
  localparam int FLAG_W  = 3;

  function automatic int entry_w(input int rw);
    return rw + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_result_queue_sm_canon.sv
// Combinational canonicaliser for sign-magnitude results: builds the stored
// entry and flags disagreement between upstream and recomputed SF/ZF.
module sm_canon
  import alu_result_queue_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0]        in_r,
  input  logic                 in_sf,
  input  logic                 in_zf,
  input  logic                 in_dzf,
  output logic [RW+FLAG_W-1:0] entry,
  output logic                 mismatch
);

  logic [RW-2:0] mag;
  logic          neg;
  logic          mag_zero;

  assign mag      = in_r[RW-2:0];
  assign neg      = in_r[RW-1];
  assign mag_zero = (mag == '0);

  always_comb begin
    entry    = '0;
    mismatch = 1'b0;
    if (in_dzf) begin
      entry[RW+DZF_OFS] = 1'b1;
    end else if (mag_zero) begin
      // Negative zero arriving with SF=1 is accepted as consistent.
      entry[RW+ZF_OFS] = 1'b1;
      mismatch         = !in_zf || (in_sf && !neg);
    end else begin
      entry[RW-1:0]     = in_r;
      entry[RW+SF_OFS]  = neg;
      mismatch          = (in_sf != neg) || in_zf;
    end
  end

endmodule

// File: rtl/alu_result_queue.sv
// First-word-fall-through result FIFO behind the mul/div units; stores
// canonical entries and presents sign-magnitude and two's-complement forms.
module alu_result_queue
  import alu_result_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RW    = RW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RW-1:0]            in_r,
  input  logic                     in_sf,
  input  logic                     in_zf,
  input  logic                     in_dzf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_r,
  output logic [RW-1:0]            out_tc,
  output logic                     out_sf,
  output logic                     out_zf,
  output logic                     out_dzf,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_dzf,
  output logic                     flag_err
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             EW   = entry_w(RW);
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [EW-1:0] canon;
  logic [EW-1:0] head;
  logic [RW-1:0] mag_ext;
  logic          mismatch;
  logic          push;
  logic          pop;

  sm_canon #(.RW(RW)) u_canon (
    .in_r     (in_r),
    .in_sf    (in_sf),
    .in_zf    (in_zf),
    .in_dzf   (in_dzf),
    .entry    (canon),
    .mismatch (mismatch)
  );

  // Handshake: a beat transfers on a side exactly when valid && ready are both
  // high at the rising edge; valid never waits on ready. A full queue still
  // accepts when the head is popped in the same cycle.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count != FULL) || pop;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      sticky_dzf <= 1'b0;
      flag_err   <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= canon;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A same-cycle set wins over the clear.
      if (push && in_dzf)        sticky_dzf <= 1'b1;
      else if (clr_sticky)       sticky_dzf <= 1'b0;
      if (push && mismatch)      flag_err   <= 1'b1;
      else if (clr_sticky)       flag_err   <= 1'b0;
    end
  end

  assign head    = mem[rptr];
  assign out_r   = head[RW-1:0];
  assign out_sf  = head[RW+SF_OFS];
  assign out_zf  = head[RW+ZF_OFS];
  assign out_dzf = head[RW+DZF_OFS];

  assign mag_ext = {1'b0, out_r[RW-2:0]};
  assign out_tc  = out_r[RW-1] ? -mag_ext : mag_ext;

endmodule
